clk_div_prog: RTL
=================

Name: clk_div_prog

Overview:
Runtime-programmable integer clock divider, successor to the fixed-ratio divider. It generates a 50%-duty divided clock for both even and odd ratios, using a falling-edge retime flop for the odd case. Ratio changes are glitch-free, taking effect only at a period boundary. It also emits a one-cycle period-start tick for synchronous logic in the clk domain.

Parameters:
WIDTH, 8, width of divisor input, divisor register and internal counter
DEFAULT_DIV, 5, divisor loaded at reset; legal range 1..2^WIDTH-1 (elaboration error otherwise)

Ports:
clk  input  1  source clock; all state on posedge except one negedge retime flop
reset  input  1  synchronous, active-high reset
en  input  1  divider enable
div_in  input  WIDTH  requested divisor D
div_load  input  1  one-cycle strobe capturing div_in
clk_out  output  1  divided clock
tick  output  1  registered one-cycle pulse at each clk_out period start
div_active  output  WIDTH  divisor currently in effect
div_err  output  1  one-cycle pulse: div_load with div_in==0 rejected

Behaviour:
- Reset, sampled at posedge:
  - div_q=DEFAULT_DIV, cnt=DEFAULT_DIV-1
  - pos_q=0, tick=0, div_err=0
  - pending register cleared (pend_vld=0)
- Negedge flop neg_q clears at any falling edge where reset=1.
- Reset overrides en and div_load in the same cycle.
- Mid-period reset: clk_out low by the next falling edge. Any pending load is discarded.
- Counter: cnt runs 0..D-1 while en=1. At cnt==D-1 it wraps to 0; that posedge is the period boundary.
- Output shaping, H=(D+1)>>1:
  - On each enabled posedge, pos_q <= (next_cnt < H).
  - neg_q <= pos_q on every negedge.
  - D even: clk_out = pos_q; high D/2 cycles.
  - D odd (>1): clk_out = pos_q & neg_q; high D/2 cycles (x.5); rising edge aligned to the falling clk edge after the boundary.
  - D==1: clk_out = clk while en=1 (bypass); tick constantly 1.
- tick: registered; high for exactly the cycle following each boundary posedge.
- Ratio load:
  - div_load with div_in!=0 stores it into pend, sets pend_vld.
  - A later load before the boundary overwrites it; last load wins.
  - At the boundary with pend_vld=1: div_q<=pend, pend_vld<=0. The new period already uses the new D and H.
  - div_load coincident with the boundary applies div_in directly at that boundary.
  - The current period always completes at the old ratio.
- div_load with div_in==0: ignored, pend unchanged, div_err=1 for the following cycle.
- en=0:
  - cnt forced to div_q-1, pos_q=0, so clk_out is low within one cycle (odd D: at the next posedge).
  - Any pending value is applied immediately.
  - On re-assertion, the first posedge is a boundary: clk_out rises and tick pulses.
- div_active = div_q, registered.
- No combinational path from div_in to clk_out except the D==1 bypass.

Test Plan:
1. Reset, en=1, defaults (D=5) -> clk_out period 5 clk, high 2.5 clk; tick every 5th cycle; div_active=5.
2. div_load div_in=4 at cnt=2 -> current period still 5 clk; following periods 4 clk, high exactly 2; div_active becomes 4 at the boundary.
3. Two loads 6 then 3 before the same boundary -> next period 3 clk (high 1.5); 6 never observed.
4. div_load div_in=0 -> div_err high 1 cycle; div_active and clk_out period unchanged.
5. D=2 then D=1 -> 50% output at clk/2, then clk_out mirrors clk; tick continuously high.
6. en low mid-period with D=7 -> clk_out low within 1 cycle. Re-enable -> clk_out rises, tick on the first posedge. Reset mid-period with a pending load -> outputs at reset values, pending value lost, div_active=5.

Source files
------------

// File: rtl/clk_div_prog.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | clk_div_prog : runtime-programmable 50%-duty integer clock divider        |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module clk_div_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] div_active,
  output logic             div_err
);

  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH:0]   ONE_X     = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] DEFAULT_Q = WIDTH'(DEFAULT_DIV);

  if ((DEFAULT_DIV < 1) || (longint'(DEFAULT_DIV) > ((longint'(1) << WIDTH) - 1))) begin : g_bad_default
    $error("clk_div_prog: DEFAULT_DIV outside 1..2^WIDTH-1");
  end

  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] pend;
  logic             pend_vld;
  logic             pos_q;
  logic             neg_q;

  logic             load_ok;
  logic             boundary;
  logic [WIDTH-1:0] next_div;
  logic [WIDTH-1:0] next_cnt;
  logic [WIDTH:0]   half;

  // At a boundary the new period is shaped with the incoming divisor.
  always_comb begin
    load_ok  = div_load && (div_in != '0);
    boundary = (cnt == (div_q - ONE));
    next_div = load_ok ? div_in : (pend_vld ? pend : div_q);
    if (boundary) begin
      next_cnt = '0;
      half     = ({1'b0, next_div} + ONE_X) >> 1;
    end else begin
      next_cnt = cnt + ONE;
      half     = ({1'b0, div_q} + ONE_X) >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q    <= DEFAULT_Q;
      cnt      <= DEFAULT_Q - ONE;
      pend     <= '0;
      pend_vld <= 1'b0;
      pos_q    <= 1'b0;
      tick     <= 1'b0;
      div_err  <= 1'b0;
    end else begin
      div_err <= div_load && (div_in == '0);
      if (!en) begin
        // Parked one step before a boundary so re-enable starts a fresh period.
        div_q    <= next_div;
        cnt      <= next_div - ONE;
        pend_vld <= 1'b0;
        pos_q    <= 1'b0;
        tick     <= 1'b0;
      end else if (boundary) begin
        div_q    <= next_div;
        cnt      <= '0;
        pend_vld <= 1'b0;
        pos_q    <= ({1'b0, next_cnt} < half);
        tick     <= 1'b1;
      end else begin
        cnt   <= next_cnt;
        pos_q <= ({1'b0, next_cnt} < half);
        tick  <= 1'b0;
        if (load_ok) begin
          pend     <= div_in;
          pend_vld <= 1'b1;
        end
      end
    end
  end

  // Half-cycle retime that trims odd-ratio high time to D/2 cycles.
  always_ff @(negedge clk) begin
    if (reset) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= pos_q;
    end
  end

  always_comb begin
    if (en && (div_q == ONE)) begin
      clk_out = clk;
    end else if (div_q[0]) begin
      clk_out = pos_q & neg_q;
    end else begin
      clk_out = pos_q;
    end
  end

  assign div_active = div_q;

endmodule
`default_nettype wire
